// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, issues in-order imem reads and buffers returned words in a DEPTH-slot queue.
// Optional `FETCH_PERF_EN adds saturating fetch-bubble and redirect counters.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [5:0]  op_d,
    input  logic [1:0]  stop_d,
    input  logic [31:0] jump_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic        ins_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(DEPTH + 1);
    localparam int          DW        = 8;
    localparam logic [31:0] NOP       = 32'hdc00_0000;
    localparam logic [5:0]  OP_HALT   = 6'b111111;
    localparam logic [1:0]  STOP_ADV  = 2'b00;
    localparam logic [1:0]  STOP_JUMP = 2'b11;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] used_q, used_d, nfill_q, nfill_d;
    logic [DW-1:0] drop_q, drop_d;
    logic          finish_q, finish_d;
    logic [31:0]   slot_pc_q  [DEPTH];
    logic [31:0]   slot_ins_q [DEPTH];

    logic          halt, redirect, active, has_head;
    logic          issue, pop, resp, fill;
    logic [CW-1:0] unfilled;
    logic [PW-1:0] fill_idx;

    // Slots head..head+nfill-1 are filled; the remaining allocated slots await data in order.
    assign halt     = (op_d == OP_HALT);
    assign redirect = (stop_d == STOP_JUMP);
    assign active   = !finish_q && !halt;
    assign unfilled = used_q - nfill_q;
    assign has_head = (nfill_q != '0);
    assign fill_idx = head_q + PW'(nfill_q);

    assign imem_req  = rstd && !finish_q && (used_q < CW'(DEPTH)) && !redirect && !halt;
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_ready;
    assign pop       = active && !redirect && (stop_d == STOP_ADV) && has_head;
    assign resp      = imem_rvalid && active && ((drop_q != '0) || (unfilled != '0));
    assign fill      = resp && !redirect && (drop_q == '0);

    assign ins_valid = has_head && !finish_q;
    assign ins_out   = ins_valid ? slot_ins_q[head_q] : NOP;
    assign pc_out    = slot_pc_q[head_q];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        pc_d     = pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        used_d   = used_q;
        nfill_d  = nfill_q;
        drop_d   = drop_q;
        finish_d = finish_q;
        if (finish_q) begin
            finish_d = 1'b1;
        end else if (halt) begin
            finish_d = 1'b1;
            head_d   = tail_q;
            used_d   = '0;
            nfill_d  = '0;
        end else if (redirect) begin
            // A response arriving now belongs to an unfilled slot or an earlier drop, so it retires one.
            pc_d    = jump_pc;
            head_d  = tail_q;
            used_d  = '0;
            nfill_d = '0;
            drop_d  = drop_q + DW'(unfilled) - DW'(resp);
        end else begin
            if (issue) begin
                tail_d = tail_q + PW'(1);
                pc_d   = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            used_d  = used_q + CW'(issue) - CW'(pop);
            nfill_d = nfill_q + CW'(fill) - CW'(pop);
            if (resp && (drop_q != '0)) begin
                drop_d = drop_q - DW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            pc_q     <= PC_RESET;
            head_q   <= '0;
            tail_q   <= '0;
            used_q   <= '0;
            nfill_q  <= '0;
            drop_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            used_q   <= used_d;
            nfill_q  <= nfill_d;
            drop_q   <= drop_d;
            finish_q <= finish_d;
        end
    end

    // NOTE: slot pcs are reset because pc_out must read 0 in reset; slot words are masked by ins_valid and need none.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i] <= '0;
            end
        end else if (issue) begin
            slot_pc_q[tail_q] <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            slot_ins_q[fill_idx] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((stop_d == STOP_ADV) && !finish_q && !has_head && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (active && redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked against an epoch-tagged
// architectural model (expected fetch stream, occupancy, in-order memory with random latency).
module tb_fetch_unit;

    localparam logic [31:0] PC_RST = 32'h0000_0100;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'hdc00_0000;

    logic        clk;
    logic        rstd;
    logic [5:0]  op_d;
    logic [1:0]  stop_d;
    logic [31:0] jump_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic        ins_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_unit #(.PC_RESET(PC_RST), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstd       (rstd),
        .op_d       (op_d),
        .stop_d     (stop_d),
        .jump_pc    (jump_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .ins_out    (ins_out),
        .ins_valid  (ins_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          issued, arrived, consumed;
    int          lat_min = 1, lat_max = 1;
    logic        fin;
    logic [31:0] exp_addr, exp_pc;
    logic [31:0] stall_m, flush_m;

    // Memory contents: 0x100 -> 0x11111111, 0x104 -> 0x22222222, ...
    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return (((a - PC_RST) >> 2) + 32'd1) * 32'h1111_1111;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic [1:0] stop, input logic [5:0] op, input logic [31:0] jpc, input logic rdy);
        logic e_req, e_valid, halt, redir;
        req_t r;
        stop_d     = stop;
        op_d       = op;
        jump_pc    = jpc;
        imem_ready = rdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ins_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        halt    = (op == 6'b111111);
        redir   = (stop == 2'b11);
        e_req   = rstd && !fin && ((issued - consumed) < DEPTH) && !redir && !halt;
        e_valid = rstd && !fin && (arrived > consumed);
        @(negedge clk);
        check("imem_req", 32'(imem_req), 32'(e_req));
        check("ins_valid", 32'(ins_valid), 32'(e_valid));
        if (e_req && rdy) check("imem_addr", imem_addr, exp_addr);
        if (e_valid) begin
            check("pc_out", pc_out, exp_pc);
            check("ins_out", ins_out, ins_of(exp_pc));
        end else begin
            check("ins_out_nop", ins_out, NOP);
        end
        if (!rstd) check("pc_out_rst", pc_out, 32'h0);
`ifdef FETCH_PERF_EN
        check("perf_stall", perf_stall_cnt, stall_m);
        check("perf_flush", perf_flush_cnt, flush_m);
`endif
        if (rstd) begin
            if (imem_rvalid) begin
                r = mq.pop_front();
                if (!fin && !halt && !redir && r.epoch == epoch) arrived++;
            end
            if (stop == 2'b00 && !fin && !e_valid) stall_m++;
            if (fin) begin
                fin = 1'b1;
            end else if (halt) begin
                fin = 1'b1;
                epoch++;
            end else if (redir) begin
                epoch++;
                issued   = 0;
                arrived  = 0;
                consumed = 0;
                exp_addr = jpc;
                exp_pc   = jpc;
                flush_m++;
            end else begin
                if (e_req && rdy) begin
                    mq.push_back('{addr: exp_addr, epoch: epoch,
                                   due: cyc + int'($urandom_range(lat_max, lat_min))});
                    issued++;
                    exp_addr += 32'd4;
                end
                if (stop == 2'b00 && e_valid) begin
                    consumed++;
                    exp_pc += 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstd = 1'b0;
        mq.delete();
        fin      = 1'b0;
        epoch++;
        issued   = 0;
        arrived  = 0;
        consumed = 0;
        exp_addr = PC_RST;
        exp_pc   = PC_RST;
        stall_m  = 0;
        flush_m  = 0;
        repeat (2) step(2'b00, 6'h00, 32'h0, 1'b1);
        rstd = 1'b1;
    endtask

    initial begin
        int r;
        logic [1:0]  s;
        logic [31:0] j;
        rstd = 1'b0; op_d = '0; stop_d = '0; jump_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        do_reset();

        // Plain streaming with 1-cycle latency.
        lat_min = 1; lat_max = 1;
        repeat (8) step(2'b00, 6'h00, 32'h0, 1'b1);

        // Stall: head held, queue fills to DEPTH, then resumes contiguously.
        repeat (5) step(2'b01, 6'h00, 32'h0, 1'b1);
        step(2'b10, 6'h00, 32'h0, 1'b1);
        repeat (6) step(2'b00, 6'h00, 32'h0, 1'b1);

        // Redirect with requests in flight (latency 3).
        lat_min = 3; lat_max = 3;
        repeat (2) step(2'b00, 6'h00, 32'h0, 1'b1);
        step(2'b11, 6'h00, 32'h400, 1'b1);
        repeat (12) step(2'b00, 6'h00, 32'h0, 1'b1);

        // Redirect in the same cycle as a response.
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 20 && !(mq.size() > 0 && mq[0].due <= cyc); k++)
            step(2'b00, 6'h00, 32'h0, 1'b1);
        step(2'b11, 6'h00, 32'h800, 1'b1);
        repeat (12) step(2'b00, 6'h00, 32'h0, 1'b1);

        // pc wrap across 2^32.
        lat_min = 1; lat_max = 2;
        step(2'b11, 6'h00, 32'hffff_fff8, 1'b1);
        repeat (12) step(2'b00, 6'h00, 32'h0, 1'b1);

        // Halt is sticky; reset restarts fetch.
        step(2'b00, 6'b111111, 32'h0, 1'b1);
        repeat (6) step(2'b00, 6'h00, 32'h0, 1'b1);
        step(2'b11, 6'h00, 32'h40, 1'b1);
        do_reset();
        repeat (6) step(2'b00, 6'h00, 32'h0, 1'b1);

        // Memory not ready for 3 cycles, then latency 3.
        lat_min = 3; lat_max = 3;
        repeat (3) step(2'b00, 6'h00, 32'h0, 1'b0);
        repeat (14) step(2'b00, 6'h00, 32'h0, 1'b1);

        // Random traffic.
        lat_min = 1; lat_max = 4;
        repeat (3000) begin
            r = int'($urandom_range(99));
            s = (r < 60) ? 2'b00 : (r < 75) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
            j = {$urandom, 2'b00} >> 0;
            j = {j[31:2], 2'b00};
            if (fin && $urandom_range(9) == 0) do_reset();
            else if ($urandom_range(299) == 0) do_reset();
            else step(s, ($urandom_range(99) == 0) ? 6'b111111 : 6'(($urandom_range(62))),
                      j, ($urandom_range(3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that feeds the fetch/decode pipeline register with pc_out/ins_out each cycle.
- Owns the program counter and issues in-order read requests to instruction memory over a req/ready + rvalid interface.
- Buffers returned instructions in a small slot queue.
- Obeys decode-stage stall/jump codes (stop_d) and the halt opcode (op_d), using the same codes and NOP encoding as the decode side.

Parameters:
PC_RESET, 32'h00000000, PC value loaded on reset.
DEPTH, 2, number of buffer slots and maximum in-flight plus buffered instructions (power of two, 2..8).

Ports:
clk  input  1  clock; all state updates on rising edge.
rstd  input  1  asynchronous reset, active low.
op_d  input  6  opcode currently in decode; 6'b111111 = halt.
stop_d  input  2  2'b00 = advance; 2'b11 = jump/redirect; 2'b01 and 2'b10 = stall.
jump_pc  input  32  redirect target, sampled when stop_d==2'b11.
imem_req  output  1  request valid.
imem_addr  output  32  request byte address (the pc register).
imem_ready  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  read data valid; responses return in request order, latency of 1 or more cycles.
imem_rdata  input  32  instruction word.
pc_out  output  32  pc of the buffer head.
ins_out  output  32  head instruction if the head slot is filled, else NOP 32'hdc000000.
ins_valid  output  1  head slot is filled and the block is not finished.

Behaviour:
Reset values (any time rstd=0, including mid-transfer):
- pc=PC_RESET; all slots empty; outstanding=0; drop_cnt=0; finish=0.
- imem_req=0, pc_out=0, ins_out=32'hdc000000, ins_valid=0.

Slot queue:
- Circular queue of DEPTH slots, each holding {pc, ins, filled}, with head/tail pointers that wrap modulo DEPTH.
- used = number of allocated slots.

Issue:
- imem_req=1 when !finish && used<DEPTH && stop_d!=2'b11 && op_d!=6'b111111.
- On imem_req && imem_ready: allocate a slot at tail with its pc field set to the current pc and filled=0, then pc <= pc+4 (wraps mod 2^32).

Response:
- imem_rvalid with drop_cnt>0: discard the data, drop_cnt decrements.
- imem_rvalid with drop_cnt==0: write ins into the oldest unfilled allocated slot and set filled=1.
- imem_rvalid with no outstanding request: ignored.

Consume:
- When stop_d==2'b00 && !finish && head filled: pop the head.
- Output is combinational from the head slot. Latency from rvalid to ins_valid is 1 cycle.
- Stall (2'b01 or 2'b10) holds the head and pc; issue continues until the queue is full.

Redirect (stop_d==2'b11):
- Next cycle: pc=jump_pc and all slots are freed.
- drop_cnt = drop_cnt + (allocated unfilled slots) − (1 if an rvalid is being counted this cycle).
- No issue and no pop occur in the redirect cycle.
- A response in the same cycle as the redirect is discarded.

Halt (op_d==6'b111111):
- Sets finish (sticky until reset) and frees all slots.
- After halt: imem_req=0, ins_out=NOP, ins_valid=0. Late responses are ignored.

Simultaneous events:
- Pop and allocate in the same cycle are both honoured; used is unchanged.
- Priority order: reset > halt > redirect > stall/advance.

Optional Feature:
FETCH_PERF_EN:
- When defined, adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0 and saturating at 32'hffffffff.
- perf_stall_cnt increments on each cycle with stop_d==2'b00 && !finish && head not filled (fetch bubble).
- perf_flush_cnt increments on each redirect.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset with PC_RESET=0x100, imem_ready=1, 1-cycle latency returning 0x11111111/0x22222222… -> imem_addr sequence 0x100, 0x104, …; pc_out/ins_out = 0x100/0x11111111 then 0x104/0x22222222 on consecutive cycles, ins_valid=1.
2. Hold stop_d=2'b01 for 5 cycles -> head stays 0x108; exactly DEPTH slots allocated, then imem_req=0; release -> contiguous 0x108, 0x10C with no gap or duplicate.
3. stop_d=2'b11 with jump_pc=0x400 while 2 requests are in flight -> both late responses discarded; next imem_addr=0x400; first valid pc_out=0x400; ins_out=NOP in between.
4. Redirect in the same cycle as an rvalid -> that data never appears at ins_out; drop_cnt returns to 0 after the remaining in-flight responses arrive.
5. op_d=6'b111111 -> from the next cycle imem_req=0, ins_out=32'hdc000000 permanently; assert rstd=0 -> pc=PC_RESET and fetch resumes.
6. imem_ready low for 3 cycles, then latency of 3 cycles -> ins_valid=0 with ins_out=NOP during the gap; order is preserved; with FETCH_PERF_EN, perf_stall_cnt counts the bubble cycles exactly.
